z80_bus_arbiter: RTL and testbench
==================================

# z80_bus_arbiter

Shares the Z80 external bus between the CPU and up to `NREQ` DMA-style requesters. The arbiter drives `nBUSRQ` and waits for `nBUSACK`, then gives one requester the bus at a time. Ownership rotates round-robin with a bounded hold time. It sits beside the CPU on the board-level bus, on the testbench side of the pin interface, and all logic runs on `CPUCLK`.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, range 1..8.
- `MAX_HOLD`, 64: cycles a grant may last while another requester is pending. Range 2..255.
- `CPU_GAP`, 4: minimum cycles the CPU keeps the bus after release before the next `nBUSRQ`. Range 1..255.

Ports:
- `CPUCLK` in 1: clock. Single clock domain.
- `RESET` in 1: reset, synchronous and active-high.
- `nBUSACK` in 1: bus acknowledge from the CPU, active-low, synchronous to `CPUCLK`.
- `req` in `NREQ`: request lines, one per requester, level-sensitive.
- `nBUSRQ` out 1: bus request to the CPU, active-low, registered.
- `gnt` out `NREQ`: grants, one-hot or zero, registered.
- `owner` out 3: index of the current grantee. Valid only while `|gnt`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Reset values: `nBUSRQ`=1, `gnt`=0, `owner`=0, `busy`=0, state=IDLE.
  - The round-robin pointer resets to `NREQ-1`, so requester 0 is first.
  - The gap counter resets to `CPU_GAP` (already satisfied).
- IDLE: `gap_cnt` increments and saturates at `CPU_GAP`.
  - When `|req` and `gap_cnt==CPU_GAP`, go to REQ and drive `nBUSRQ`=0.
- REQ: hold `nBUSRQ`=0 until `nBUSACK`==0 is sampled.
  - On that sample, pick the winner and go to GRANT, setting the winner's `gnt` bit and `owner`.
  - If `req` drops to 0 before the acknowledge arrives, keep waiting for `nBUSACK`, then go to RELEASE. A Z80 bus request cannot be withdrawn.
- Winner selection: the first set `req` bit searching upward from `ptr+1`, modulo `NREQ`. On each grant, `ptr` becomes the winner.
- GRANT: `hold_cnt` counts cycles from 1.
  - The owner drops its `req` → go to TURN.
  - Or `hold_cnt==MAX_HOLD` and another `req` bit is set → go to TURN (preemption).
  - With no competitor, the grant is unbounded and `hold_cnt` saturates.
- TURN: exactly one cycle with `gnt`=0 and `nBUSRQ` still 0 (bus turnaround).
  - Any `req` set → GRANT to the next round-robin winner. A preempted owner may still be requesting and competes normally.
  - No `req` set → RELEASE.
- RELEASE: drive `nBUSRQ`=1 and wait for `nBUSACK`==1.
  - On that sample, go to IDLE and clear `gap_cnt` to 0.
- `nBUSACK` going high in GRANT or TURN is a protocol error. Drop `gnt` on the next edge and go to RELEASE.
- `RESET` in any state aborts the operation on the next edge, and all outputs return to their reset values. A requester that loses `gnt` to reset must stop driving the bus in that same cycle.

## Timing
- Every output is registered and changes only on the rising edge of `CPUCLK`.
- IDLE→REQ: `req` sampled high at edge n → `nBUSRQ`=0 after edge n.
- REQ→GRANT: `nBUSACK`=0 sampled at edge m → `gnt` valid after edge m. Grant latency is one cycle from acknowledge.
- Owner drops `req` at edge k:
  - `gnt`=0 after k (TURN).
  - Next grant after k+1, or `nBUSRQ`=1 after k+1.
- Preemption: `gnt` falls on the edge where `hold_cnt` equals `MAX_HOLD`, so the owner holds for exactly `MAX_HOLD` cycles.
- Simultaneous events:
  - Owner drops `req` and hold expires in the same cycle → treated as a drop; same path.
  - `req` rises in RELEASE → ignored until IDLE and the `CPU_GAP` window has elapsed.
- The CPU is guaranteed at least `CPU_GAP` cycles with `nBUSRQ`=1 between release and the next request.

## Structure
- Shared package `z80_bus_pkg`:
  - state enum `arb_state_t` with values IDLE, REQ, GRANT, TURN, RELEASE;
  - owner-width constant `OWNER_W`=3.
- One sub-module, `rr_pick`: purely combinational.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot winner, index, and valid.
- Counters (`hold_cnt`, `gap_cnt`) and the FSM live in the top module.
- The top binds to the pin interface through the `tb` modport side.
- Only `nBUSRQ` is driven; all other pins are observed.

## Test plan
- Reset, then `req`=4'b0001 with the CPU model acknowledging after 3 cycles.
  - `nBUSRQ` falls 1 cycle after `req`.
  - `gnt`=0001 and `owner`=0 one cycle after `nBUSACK` falls.
  - Release → one TURN cycle, then `nBUSRQ`=1, then IDLE.
- `req`=4'b1011 held high, `MAX_HOLD`=8.
  - Grants rotate 0→1→3→0, each lasting exactly 8 cycles.
  - Exactly 1 zero-`gnt` cycle between grants, and `nBUSRQ` stays low throughout.
- Single requester holding for 200 cycles with no competitor → no preemption; `gnt` stays asserted.
- Release followed by an immediate new `req`, `CPU_GAP`=4 → `nBUSRQ` stays high for 4 cycles after `nBUSACK` rises, then falls.
- `RESET` asserted mid-GRANT → next edge gives `gnt`=0, `nBUSRQ`=1, `busy`=0. The next grant goes to requester 0.
- `nBUSACK` forced high during GRANT → `gnt` drops on the next edge and the FSM reaches RELEASE.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 bus arbiter.
package z80_bus_pkg;

  // Width of the owner index; wide enough for up to 8 requesters.
  localparam int OWNER_W = 3;

  // Width of the hold and gap counters; both limits are at most 255.
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    GRANT   = 3'd2,
    TURN    = 3'd3,
    RELEASE = 3'd4
  } arb_state_t;

  // Counter increment that sticks at its limit instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value,
                                              input logic [CNT_W-1:0] limit);
    return (value >= limit) ? value : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/z80_bus_arbiter_rr_pick.sv
// Combinational round-robin winner search: first set request above ptr, wrapping.
module rr_pick
  import z80_bus_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] ptr,
  output logic [NREQ-1:0]    winOneHot,
  output logic [OWNER_W-1:0] winIdx,
  output logic               winValid
);

  // candIdx[k] is the requester examined at search position k (ptr+1+k mod NREQ).
  logic [OWNER_W-1:0] candIdx [NREQ];
  logic [NREQ-1:0]    candHit;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      assign candIdx[gi] = OWNER_W'((int'(ptr) + gi + 1) % NREQ);
    end
  endgenerate

  // Look up whether the requester at each search position is asking for the bus.
  always_comb begin
    candHit = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (candIdx[k] == OWNER_W'(j)) begin
          candHit[k] = req[j];
        end
      end
    end
  end

  // Lowest search position wins, so scan from the far end and let nearer hits override.
  always_comb begin
    winIdx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (candHit[k]) begin
        winIdx = candIdx[k];
      end
    end
  end

  assign winValid = |candHit;

  // Expand the winning index into a one-hot grant vector.
  always_comb begin
    winOneHot = '0;
    for (int k = 0; k < NREQ; k++) begin
      winOneHot[k] = winValid && (winIdx == OWNER_W'(k));
    end
  end

endmodule

// File: rtl/z80_bus_arbiter.sv
// Z80 bus arbiter: requests the bus from the CPU and hands it to one requester at a time,
// rotating round-robin with a bounded hold while others wait.
module z80_bus_arbiter
  import z80_bus_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 64,
  parameter int CPU_GAP  = 4
) (
  input  logic               CPUCLK,
  input  logic               RESET,
  input  logic               nBUSACK,
  input  logic [NREQ-1:0]    req,
  output logic               nBUSRQ,
  output logic [NREQ-1:0]    gnt,
  output logic [OWNER_W-1:0] owner,
  output logic               busy
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(CPU_GAP);

  arb_state_t         stateReg, stateNext;
  logic [OWNER_W-1:0] ptrReg, ptrNext;
  logic [CNT_W-1:0]   holdCntReg, holdCntNext;
  logic [CNT_W-1:0]   gapCntReg, gapCntNext;

  logic               nBusRqNext;
  logic [NREQ-1:0]    gntNext;
  logic [OWNER_W-1:0] ownerNext;
  logic               busyNext;

  logic [NREQ-1:0]    pickOneHot;
  logic [OWNER_W-1:0] pickIdx;
  logic               pickValid;

  logic anyReq;
  logic ownerReq;
  logic rivalReq;
  logic holdExpired;
  logic gapDone;
  logic newGrant;

  // The registered gnt vector doubles as the current owner's mask.
  assign anyReq      = |req;
  assign ownerReq    = |(req & gnt);
  assign rivalReq    = |(req & ~gnt);
  assign holdExpired = (holdCntReg == HOLD_LIM);
  assign gapDone     = (gapCntReg == GAP_LIM);
  assign newGrant    = (stateNext == GRANT) && (stateReg != GRANT);
  assign ptrNext     = newGrant ? pickIdx : ptrReg;

  rr_pick #(
    .NREQ(NREQ)
  ) uPick (
    .req      (req),
    .ptr      (ptrReg),
    .winOneHot(pickOneHot),
    .winIdx   (pickIdx),
    .winValid (pickValid)
  );

  // State and round-robin pointer; pointer starts at NREQ-1 so requester 0 goes first.
  always_ff @(posedge CPUCLK) begin
    if (RESET) begin
      stateReg <= IDLE;
      ptrReg   <= OWNER_W'(NREQ - 1);
    end else begin
      stateReg <= stateNext;
      ptrReg   <= ptrNext;
    end
  end

  // Next-state rules; a high nBUSACK while we own the bus is a protocol error and wins.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (anyReq && gapDone) stateNext = REQ;
      end
      REQ: begin
        // A Z80 bus request cannot be withdrawn, so wait for the acknowledge regardless.
        if (!nBUSACK) stateNext = pickValid ? GRANT : RELEASE;
      end
      GRANT: begin
        if (nBUSACK)                       stateNext = RELEASE;
        else if (!ownerReq)                stateNext = TURN;
        else if (holdExpired && rivalReq)  stateNext = TURN;
      end
      TURN: begin
        if (nBUSACK)        stateNext = RELEASE;
        else if (pickValid) stateNext = GRANT;
        else                stateNext = RELEASE;
      end
      RELEASE: begin
        if (nBUSACK) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Output values for the state being entered, so every output comes straight from a flop.
  always_comb begin
    nBusRqNext = 1'b1;
    gntNext    = '0;
    ownerNext  = owner;
    busyNext   = (stateNext != IDLE);
    case (stateNext)
      REQ, TURN: begin
        nBusRqNext = 1'b0;
      end
      GRANT: begin
        nBusRqNext = 1'b0;
        if (newGrant) begin
          gntNext   = pickOneHot;
          ownerNext = pickIdx;
        end else begin
          gntNext = gnt;
        end
      end
      default: begin
        nBusRqNext = 1'b1;
      end
    endcase
  end

  // Hold counter runs 1..MAX_HOLD during a grant; gap counter measures CPU time after release.
  always_comb begin
    holdCntNext = '0;
    if (newGrant) begin
      holdCntNext = CNT_W'(1);
    end else if ((stateReg == GRANT) && (stateNext == GRANT)) begin
      holdCntNext = satInc(holdCntReg, HOLD_LIM);
    end

    gapCntNext = gapCntReg;
    if ((stateReg == RELEASE) && (stateNext == IDLE)) begin
      gapCntNext = '0;
    end else if (stateReg == IDLE) begin
      gapCntNext = satInc(gapCntReg, GAP_LIM);
    end
  end

  // Counter registers; the gap starts satisfied so the first request goes out at once.
  always_ff @(posedge CPUCLK) begin
    if (RESET) begin
      holdCntReg <= '0;
      gapCntReg  <= GAP_LIM;
    end else begin
      holdCntReg <= holdCntNext;
      gapCntReg  <= gapCntNext;
    end
  end

  // Registered outputs.
  always_ff @(posedge CPUCLK) begin
    if (RESET) begin
      nBUSRQ <= 1'b1;
      gnt    <= '0;
      owner  <= '0;
      busy   <= 1'b0;
    end else begin
      nBUSRQ <= nBusRqNext;
      gnt    <= gntNext;
      owner  <= ownerNext;
      busy   <= busyNext;
    end
  end

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Bench for z80_bus_arbiter: a CPU bus model, a rule-level reference model feeding a
// scoreboard queue, a monitor comparing every cycle, plus directed checks.
module tb_z80_bus_arbiter;
  import z80_bus_pkg::*;

  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 8;
  localparam int CPU_GAP  = 4;

  logic               CPUCLK = 1'b0;
  logic               RESET;
  logic               nBUSACK;
  logic [NREQ-1:0]    req;
  logic               nBUSRQ;
  logic [NREQ-1:0]    gnt;
  logic [OWNER_W-1:0] owner;
  logic               busy;

  int checks = 0;
  int errors = 0;

  // CPU model knobs
  int ackDly = 3;
  int relDly = 2;
  bit forceAckHigh = 1'b0;

  z80_bus_arbiter #(
    .NREQ(NREQ), .MAX_HOLD(MAX_HOLD), .CPU_GAP(CPU_GAP)
  ) dut (
    .CPUCLK (CPUCLK),
    .RESET  (RESET),
    .nBUSACK(nBUSACK),
    .req    (req),
    .nBUSRQ (nBUSRQ),
    .gnt    (gnt),
    .owner  (owner),
    .busy   (busy)
  );

  always #5 CPUCLK = ~CPUCLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after each rising edge, after the CPU model has moved.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CPUCLK);
      #2;
    end
  endtask

  // ---------------- CPU bus model ----------------
  int cpuCnt = 0;
  initial begin
    nBUSACK = 1'b1;
    forever begin
      @(posedge CPUCLK);
      #1;
      if (forceAckHigh) begin
        nBUSACK = 1'b1;
        cpuCnt  = 0;
      end else if (!nBUSRQ) begin
        if (nBUSACK) begin
          cpuCnt++;
          if (cpuCnt > ackDly) begin nBUSACK = 1'b0; cpuCnt = 0; end
        end else cpuCnt = 0;
      end else begin
        if (!nBUSACK) begin
          cpuCnt++;
          if (cpuCnt > relDly) begin nBUSACK = 1'b1; cpuCnt = 0; end
        end else cpuCnt = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic            nbr;
    logic [NREQ-1:0] g;
    int              own;
    logic            bsy;
  } exp_t;

  exp_t expQ[$];

  string           mPhase;
  int              mGap;
  int              mLast;
  int              mHolder;
  int              mHeld;
  int              mWin;
  logic [NREQ-1:0] mMask;
  exp_t            mExp;

  // First requester found searching upward from 'from'+1, wrapping; -1 if none.
  function automatic int rrNext(input logic [NREQ-1:0] r, input int from);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(from + k) % NREQ]) return (from + k) % NREQ;
    end
    return -1;
  endfunction

  initial begin
    mPhase = "idle"; mGap = CPU_GAP; mLast = NREQ - 1; mHolder = -1; mHeld = 0;
    forever begin
      @(posedge CPUCLK);
      mMask = (mHolder >= 0) ? (NREQ'(1) << mHolder) : '0;
      if (RESET) begin
        mPhase = "idle"; mGap = CPU_GAP; mLast = NREQ - 1; mHolder = -1; mHeld = 0;
      end else if (mPhase == "idle") begin
        if (req != 0 && mGap == CPU_GAP) mPhase = "wait_ack";
        else if (mGap < CPU_GAP) mGap++;
      end else if (mPhase == "wait_ack") begin
        if (!nBUSACK) begin
          mWin = rrNext(req, mLast);
          if (mWin >= 0) begin
            mHolder = mWin; mLast = mWin; mHeld = 1; mPhase = "own";
          end else mPhase = "release";
        end
      end else if (mPhase == "own") begin
        if (nBUSACK) begin
          mPhase = "release"; mHolder = -1;
        end else if ((req & mMask) == 0 || (mHeld == MAX_HOLD && (req & ~mMask) != 0)) begin
          mPhase = "turnaround"; mHolder = -1;
        end else if (mHeld < MAX_HOLD) mHeld++;
      end else if (mPhase == "turnaround") begin
        mWin = rrNext(req, mLast);
        if (nBUSACK || mWin < 0) mPhase = "release";
        else begin
          mHolder = mWin; mLast = mWin; mHeld = 1; mPhase = "own";
        end
      end else begin
        if (nBUSACK) begin mPhase = "idle"; mGap = 0; end
      end
      mExp.nbr = !(mPhase == "wait_ack" || mPhase == "own" || mPhase == "turnaround");
      mExp.g   = (mHolder >= 0) ? (NREQ'(1) << mHolder) : '0;
      mExp.own = mHolder;
      mExp.bsy = (mPhase != "idle");
      expQ.push_back(mExp);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  exp_t monE;
  initial begin
    forever begin
      @(negedge CPUCLK);
      if (expQ.size() > 0) begin
        monE = expQ.pop_front();
        checks++;
        if (nBUSRQ !== monE.nbr || gnt !== monE.g || busy !== monE.bsy ||
            (monE.own >= 0 && int'(owner) != monE.own)) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got nBUSRQ=%b gnt=%b owner=%0d busy=%b, expected nBUSRQ=%b gnt=%b owner=%0d busy=%b",
                   $time, nBUSRQ, gnt, owner, busy, monE.nbr, monE.g, monE.own, monE.bsy);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  int              n;
  int              bad;
  int              highs;
  logic [NREQ-1:0] gs [35];
  logic            rs [35];
  int              order [4] = '{0, 1, 3, 0};

  initial begin
    RESET = 1'b1;
    req   = '0;
    tick(3);
    chk("rst_nBUSRQ", nBUSRQ, 1);
    chk("rst_gnt", gnt, 0);
    chk("rst_owner", owner, 0);
    chk("rst_busy", busy, 0);
    RESET = 1'b0;
    tick(2);

    // Single requester, CPU acknowledges after 3 cycles
    ackDly = 3; relDly = 2;
    req = 4'b0001;
    tick(1);
    chk("t1_nBUSRQ_fall", nBUSRQ, 0);
    n = 0;
    while (nBUSACK && n < 20) begin tick(1); n++; end
    chk("t1_ack_seen", nBUSACK, 0);
    chk("t1_gnt_before_ack_sample", gnt, 0);
    tick(1);
    chk("t1_gnt", gnt, 1);
    chk("t1_owner", owner, 0);
    tick(3);
    req = '0;
    tick(1);
    chk("t1_turn_gnt", gnt, 0);
    chk("t1_turn_nBUSRQ", nBUSRQ, 0);
    tick(1);
    chk("t1_release_nBUSRQ", nBUSRQ, 1);
    chk("t1_release_busy", busy, 1);
    n = 0;
    while (busy && n < 20) begin tick(1); n++; end
    chk("t1_back_to_idle", busy, 0);

    // Rotation among 0,1,3 with MAX_HOLD=8; reset puts the pointer back so 0 is first
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    req = 4'b1011;
    n = 0;
    while (gnt == 0 && n < 30) begin tick(1); n++; end
    chk("t2_first_grant", gnt, 1);
    for (int i = 0; i < 35; i++) begin
      gs[i] = gnt;
      rs[i] = nBUSRQ;
      tick(1);
    end
    bad = 0;
    highs = 0;
    for (int i = 0; i < 35; i++) begin
      // 8 grant cycles then one turnaround cycle, repeating
      if ((i % 9) < 8) begin
        if (gs[i] != (NREQ'(1) << order[i / 9])) bad++;
      end else begin
        if (gs[i] != 0) bad++;
      end
      if (rs[i]) highs++;
    end
    chk("t2_rotation_bad_cycles", bad, 0);
    chk("t2_nBUSRQ_high_cycles", highs, 0);

    // Lone requester is never preempted; we are in the turnaround cycle now
    req = 4'b0100;
    tick(2);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (gnt != 4'b0100) bad++;
      tick(1);
    end
    chk("t3_no_preempt_bad_cycles", bad, 0);
    chk("t3_gnt_still", gnt, 4);

    // Release then immediate new request: CPU keeps the bus for the gap
    req = '0;
    n = 0;
    while (!nBUSACK && n < 30) begin tick(1); n++; end
    chk("t4_ack_released", nBUSACK, 1);
    req = 4'b0001;
    tick(1);  // edge that samples the acknowledge: back to IDLE with the gap at zero
    n = 0;
    bad = 0;
    while (nBUSRQ && bad < 30) begin
      tick(1);
      bad++;
      if (nBUSRQ) n++;
    end
    chk("t4_gap_cycles", n, CPU_GAP);
    chk("t4_nBUSRQ_fell", nBUSRQ, 0);

    // Reset in the middle of a grant
    n = 0;
    while (gnt == 0 && n < 30) begin tick(1); n++; end
    chk("t5_granted", gnt, 1);
    tick(3);
    RESET = 1'b1;
    req = 4'b0011;
    tick(1);
    chk("t5_rst_gnt", gnt, 0);
    chk("t5_rst_nBUSRQ", nBUSRQ, 1);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_owner", owner, 0);
    RESET = 1'b0;
    n = 0;
    while (gnt == 0 && n < 30) begin tick(1); n++; end
    chk("t5_next_grant_req0", gnt, 1);

    // Protocol error: nBUSACK high during a grant
    tick(2);
    forceAckHigh = 1'b1;
    nBUSACK = 1'b1;
    tick(1);
    chk("t6_gnt_dropped", gnt, 0);
    chk("t6_busy_release", busy, 1);
    chk("t6_nBUSRQ_high", nBUSRQ, 1);
    forceAckHigh = 1'b0;
    tick(1);
    chk("t6_idle", busy, 0);

    // Randomised traffic checked by the scoreboard
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) == 0) req = NREQ'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) ackDly = $urandom_range(0, 4);
      if ($urandom_range(0, 49) == 0) relDly = $urandom_range(0, 3);
      RESET = ($urandom_range(0, 249) == 0);
      forceAckHigh = ($urandom_range(0, 299) == 0);
      if (forceAckHigh) nBUSACK = 1'b1;
      tick(1);
    end
    RESET = 1'b0;
    forceAckHigh = 1'b0;
    req = '0;
    tick(20);
    chk("end_scoreboard_drained", (expQ.size() <= 1) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
